// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port 64-bit-word data memory answering the memory-stage
// request interface. Byte-lane write strobes, right-justified read data, and an
// error flag for misaligned or out-of-range accesses.
//
// Storage is zero-filled one word per cycle after reset (INIT), then requests
// are accepted one per cycle (RUN).
//
// Optional build macro DATA_MEM_OUT_REG_EN: adds a second response register
// stage (latency 2 instead of 1, still one response per cycle).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | clearing word[clr_idx] to 0 each cycle; requests ignored
// ST_RUN  | ready every cycle; one read or write accepted per cycle

module data_mem_resp #(
    parameter int MEM_BYTES = 524288,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset_sync,
    input  logic              data_mem_req_i,
    input  logic [ADDR_W-1:0] data_mem_addr_i,
    input  logic [1:0]        data_mem_byte_en_i,
    input  logic              data_mem_wr_i,
    input  logic [63:0]       data_mem_wr_data_i,
    output logic              mem_ready_o,
    output logic              mem_rsp_valid_o,
    output logic              mem_rsp_err_o,
    output logic [63:0]       mem_rd_data_o
);

    localparam int WORDS = MEM_BYTES / 8;
    localparam int OFF_W = $clog2(MEM_BYTES);
    localparam int IDX_W = OFF_W - 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] clr_idx_q;
    logic [IDX_W-1:0] clr_idx_d;
    logic             ready;

    logic [63:0] mem [WORDS];

    logic             accept;
    logic [2:0]       lane;
    logic [IDX_W-1:0] widx;
    logic             misaligned;
    logic             out_of_range;
    logic             acc_err;
    logic [7:0]       size_strobe;
    logic [63:0]      size_mask;
    logic [7:0]       strobe;
    logic [63:0]      wr_shift;
    logic [63:0]      rd_word;
    logic [63:0]      rd_val;

    logic             rsp_valid_s1;
    logic             rsp_err_s1;
    logic [63:0]      rd_data_s1;

    // FSM state register and clear-index counter
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // FSM next state: walk the clear index through every word, then run
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready     = 1'b0;
        case (state_q)
            ST_INIT: begin
                // index wraps back to 0 on the last word since WORDS is a power of two
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_d   = ST_INIT;
                clr_idx_d = '0;
            end
        endcase
    end

    assign mem_ready_o = ready;
    assign accept      = data_mem_req_i & ready;
    assign lane        = data_mem_addr_i[2:0];
    assign widx        = data_mem_addr_i[OFF_W-1:3];

    // Alignment, range and size decode for the presented request
    always_comb begin
        misaligned  = 1'b0;
        size_strobe = 8'h01;
        size_mask   = 64'h0000_0000_0000_00ff;
        case (data_mem_byte_en_i)
            SZ_BYTE: begin
                misaligned  = 1'b0;
                size_strobe = 8'h01;
                size_mask   = 64'h0000_0000_0000_00ff;
            end
            SZ_HALF: begin
                misaligned  = data_mem_addr_i[0];
                size_strobe = 8'h03;
                size_mask   = 64'h0000_0000_0000_ffff;
            end
            SZ_WORD: begin
                misaligned  = (data_mem_addr_i[1:0] != 2'b00);
                size_strobe = 8'h0f;
                size_mask   = 64'h0000_0000_ffff_ffff;
            end
            SZ_DWORD: begin
                misaligned  = (data_mem_addr_i[2:0] != 3'b000);
                size_strobe = 8'hff;
                size_mask   = 64'hffff_ffff_ffff_ffff;
            end
            default: begin
                misaligned  = 1'b1;
                size_strobe = 8'h00;
                size_mask   = 64'h0;
            end
        endcase
    end

    assign out_of_range = (data_mem_addr_i >= ADDR_W'(MEM_BYTES));
    assign acc_err      = misaligned | out_of_range;

    // Aligned accesses never spill past lane 7, so the 8-bit shift loses nothing
    assign strobe   = size_strobe << lane;
    assign wr_shift = data_mem_wr_data_i << {lane, 3'b000};
    assign rd_word  = mem[widx];
    assign rd_val   = (rd_word >> {lane, 3'b000}) & size_mask;

    // Storage write port: zero-fill during INIT, strobed byte writes during RUN
    always_ff @(posedge clk) begin
        if (!reset_sync) begin
            if (state_q == ST_INIT) begin
                mem[clr_idx_q] <= '0;
            end else if (accept && data_mem_wr_i && !acc_err) begin
                for (int b = 0; b < 8; b++) begin
                    if (strobe[b]) begin
                        mem[widx][8*b +: 8] <= wr_shift[8*b +: 8];
                    end
                end
            end
        end
    end

    // First response stage: one pulse per accepted request; data only for good reads
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            rsp_valid_s1 <= 1'b0;
            rsp_err_s1   <= 1'b0;
            rd_data_s1   <= '0;
        end else begin
            rsp_valid_s1 <= accept;
            rsp_err_s1   <= accept & acc_err;
            rd_data_s1   <= (accept && !data_mem_wr_i && !acc_err) ? rd_val : '0;
        end
    end

`ifdef DATA_MEM_OUT_REG_EN
    logic        rsp_valid_s2;
    logic        rsp_err_s2;
    logic [63:0] rd_data_s2;

    // Second response stage: pure delay, so ordering and throughput are unchanged
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            rsp_valid_s2 <= 1'b0;
            rsp_err_s2   <= 1'b0;
            rd_data_s2   <= '0;
        end else begin
            rsp_valid_s2 <= rsp_valid_s1;
            rsp_err_s2   <= rsp_err_s1;
            rd_data_s2   <= rd_data_s1;
        end
    end

    assign mem_rsp_valid_o = rsp_valid_s2;
    assign mem_rsp_err_o   = rsp_err_s2;
    assign mem_rd_data_o   = rd_data_s2;
`else
    assign mem_rsp_valid_o = rsp_valid_s1;
    assign mem_rsp_err_o   = rsp_err_s1;
    assign mem_rd_data_o   = rd_data_s1;
`endif

endmodule
